// File: rtl/apb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// apb_pkg : shared state encoding and bus width defaults. Rev 1.0
// ---------------------------------------------------------------
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    // 2'b11 is deliberately left unused; the FSM treats it as illegal.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10
    } apb_state_t;

endpackage
`default_nettype wire

// File: rtl/apb_rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------
// apb_rr_pick : combinational round-robin picker. Rev 1.0
// ---------------------------------------------------------------
module apb_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    logic [NUM_REQ-1:0] cand;
    logic [IDX_W-1:0]   pos;
    int                 j;

    assign cand = req & ~mask;

    // Scan from ptr upwards with wrap; first candidate found wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        pos   = '0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            pos = IDX_W'(j);
            if (!valid && cand[pos]) begin
                valid = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_req_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------
// apb_req_arbiter : round-robin sharing of one APB master port. Rev 1.0
// ---------------------------------------------------------------
module apb_req_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                       PCLK,
    input  logic                       PRESETn,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]         done,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_err,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [ADDR_W-1:0]          PADDR,
    output logic [DATA_W-1:0]          PWDATA,
    input  logic                       PREADY,
    input  logic [DATA_W-1:0]          PRDATA,
    input  logic                       PSLVERR
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    apb_state_t         state, state_n;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_n;
    logic [IDX_W-1:0]   gnt, gnt_n;
    logic [WD_W-1:0]    wd, wd_n;
    logic               psel_n, penable_n, pwrite_n;
    logic [ADDR_W-1:0]  paddr_n;
    logic [DATA_W-1:0]  pwdata_n;
    logic [NUM_REQ-1:0] pick_mask;
    logic [IDX_W-1:0]   win_idx;
    logic               win_valid;
    logic               load;
    logic               timeout_hit;

    logic [ADDR_W-1:0]  addr_a  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign wdata_a[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    apb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req),
        .mask  (pick_mask),
        .ptr   (rr_ptr),
        .idx   (win_idx),
        .valid (win_valid)
    );

    assign timeout_hit = (TIMEOUT_CYC != 0) && !PREADY && (wd == WD_W'(TIMEOUT_CYC));

    always_comb begin
        state_n   = state;
        rr_ptr_n  = rr_ptr;
        gnt_n     = gnt;
        wd_n      = wd;
        psel_n    = PSEL;
        penable_n = PENABLE;
        pwrite_n  = PWRITE;
        paddr_n   = PADDR;
        pwdata_n  = PWDATA;
        pick_mask = '0;
        load      = 1'b0;
        done      = '0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;

        case (state)
            ST_IDLE: begin
                psel_n    = 1'b0;
                penable_n = 1'b0;
                if (win_valid) begin
                    load    = 1'b1;
                    psel_n  = 1'b1;
                    state_n = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_n = 1'b1;
                wd_n      = '0;
                state_n   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    done[gnt]      = 1'b1;
                    rsp_rdata      = PRDATA;
                    rsp_err        = PSLVERR;
                    penable_n      = 1'b0;
                    wd_n           = '0;
                    // The finishing requester still holds req this edge.
                    pick_mask[gnt] = 1'b1;
                    if (win_valid) begin
                        load    = 1'b1;
                        state_n = ST_SETUP;
                    end else begin
                        psel_n  = 1'b0;
                        state_n = ST_IDLE;
                    end
                end else if (timeout_hit) begin
                    done[gnt] = 1'b1;
                    rsp_err   = 1'b1;
                    psel_n    = 1'b0;
                    penable_n = 1'b0;
                    wd_n      = '0;
                    state_n   = ST_IDLE;
                end else begin
                    wd_n = wd + 1'b1;
                end
            end
            default: begin
                psel_n    = 1'b0;
                penable_n = 1'b0;
                wd_n      = '0;
                state_n   = ST_IDLE;
            end
        endcase

        if (load) begin
            gnt_n    = win_idx;
            paddr_n  = addr_a[win_idx];
            pwdata_n = wdata_a[win_idx];
            pwrite_n = req_write[win_idx];
            rr_ptr_n = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state   <= ST_IDLE;
            rr_ptr  <= '0;
            gnt     <= '0;
            wd      <= '0;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
        end else begin
            state   <= state_n;
            rr_ptr  <= rr_ptr_n;
            gnt     <= gnt_n;
            wd      <= wd_n;
            PSEL    <= psel_n;
            PENABLE <= penable_n;
            PWRITE  <= pwrite_n;
            PADDR   <= paddr_n;
            PWDATA  <= pwdata_n;
        end
    end

endmodule
`default_nettype wire
